// File: rtl/dpd_lut_cfg_if.sv
// Host-side command, fill-data and response channels of the DPD LUT row configuration sequencer.
interface dpd_lut_cfg_if #(
    parameter int I_DELAY_MAX = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [I_DELAY_MAX-1:0] cmd_lut_sel;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [DATA_WIDTH-1:0]  cmd_data;
    logic [ADDR_WIDTH:0]    cmd_len;
    logic                   wdat_valid;
    logic                   wdat_ready;
    logic [DATA_WIDTH-1:0]  wdat;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_data;
    logic                   rsp_err;
    logic                   busy;

    modport master (
        output cmd_valid, cmd_op, cmd_lut_sel, cmd_addr, cmd_data, cmd_len,
        input  cmd_ready,
        output wdat_valid, wdat,
        input  wdat_ready,
        output rsp_ready,
        input  rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_lut_sel, cmd_addr, cmd_data, cmd_len,
        output cmd_ready,
        input  wdat_valid, wdat,
        output wdat_ready,
        input  rsp_ready,
        output rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/dpd_lut_cfg_ctrl.sv
// Sequences host write/read/fill/clear commands onto the dpd_luts_row_v2 configuration port.
//   state  | meaning
//   IDLE   | waiting for a command, cmd_ready high
//   WR     | single write cycle on the LUT port
//   RD     | enc held RD_LATENCY cycles, doutc captured on the last
//   FILL   | one write per accepted wdat beat, address wraps
//   CLR    | zero every address of the selected LUTs
//   RSP    | response presented until rsp_ready
module dpd_lut_cfg_ctrl #(
    parameter int I_DELAY_MAX = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int RD_LATENCY  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dpd_lut_cfg_if.slave           cfg,
    output logic                   enc,
    output logic                   wec,
    output logic [I_DELAY_MAX-1:0] lutIdc,
    output logic [ADDR_WIDTH-1:0]  addrc,
    output logic [DATA_WIDTH-1:0]  dinc,
    input  logic [DATA_WIDTH-1:0]  doutc
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_CLR  = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0]    RD_LOAD  = CNT_W'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] LEN_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [2:0]             state;
    logic [I_DELAY_MAX-1:0] sel_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH:0]    beats_left;
    logic [CNT_W-1:0]       rd_cnt;
    logic                   cmd_fire;
    logic                   wdat_fire;
    logic                   sel_onehot;
    logic                   sel_bad;

    assign cmd_fire   = cfg.cmd_valid && cfg.cmd_ready;
    assign wdat_fire  = cfg.wdat_valid && cfg.wdat_ready;
    assign sel_onehot = (cfg.cmd_lut_sel & (cfg.cmd_lut_sel - 1'b1)) == '0;
    assign sel_bad    = (cfg.cmd_lut_sel == '0) || ((cfg.cmd_op == OP_RD) && !sel_onehot);

    assign cfg.rsp_valid = (state == S_RSP);
    assign cfg.busy      = (state != S_IDLE);

    // LUT port fields default to 0 every cycle; each state re-asserts what it drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            sel_q          <= '0;
            addr_q         <= '0;
            beats_left     <= '0;
            rd_cnt         <= '0;
            cfg.cmd_ready  <= 1'b0;
            cfg.wdat_ready <= 1'b0;
            cfg.rsp_data   <= '0;
            cfg.rsp_err    <= 1'b0;
            enc            <= 1'b0;
            wec            <= 1'b0;
            lutIdc         <= '0;
            addrc          <= '0;
            dinc           <= '0;
        end else begin
            enc    <= 1'b0;
            wec    <= 1'b0;
            lutIdc <= '0;
            addrc  <= '0;
            dinc   <= '0;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        cfg.cmd_ready <= 1'b0;
                        cfg.rsp_data  <= '0;
                        cfg.rsp_err   <= 1'b0;
                        sel_q         <= cfg.cmd_lut_sel;
                        addr_q        <= cfg.cmd_addr;
                        beats_left    <= (cfg.cmd_len == '0) ? LEN_FULL : cfg.cmd_len;
                        if (sel_bad) begin
                            cfg.rsp_err <= 1'b1;
                            state       <= S_RSP;
                        end else begin
                            case (cfg.cmd_op)
                                OP_WR: begin
                                    enc    <= 1'b1;
                                    wec    <= 1'b1;
                                    lutIdc <= cfg.cmd_lut_sel;
                                    addrc  <= cfg.cmd_addr;
                                    dinc   <= cfg.cmd_data;
                                    state  <= S_WR;
                                end
                                OP_RD: begin
                                    enc    <= 1'b1;
                                    lutIdc <= cfg.cmd_lut_sel;
                                    addrc  <= cfg.cmd_addr;
                                    rd_cnt <= RD_LOAD;
                                    state  <= S_RD;
                                end
                                OP_FILL: begin
                                    cfg.wdat_ready <= 1'b1;
                                    state          <= S_FILL;
                                end
                                OP_CLR: begin
                                    enc    <= 1'b1;
                                    wec    <= 1'b1;
                                    lutIdc <= cfg.cmd_lut_sel;
                                    state  <= S_CLR;
                                end
                            endcase
                        end
                    end else begin
                        cfg.cmd_ready <= 1'b1;
                    end
                end
                S_WR: state <= S_RSP;
                S_RD: begin
                    if (rd_cnt == '0) begin
                        cfg.rsp_data <= doutc;
                        state        <= S_RSP;
                    end else begin
                        rd_cnt <= rd_cnt - 1'b1;
                        enc    <= 1'b1;
                        lutIdc <= lutIdc;
                        addrc  <= addrc;
                    end
                end
                S_FILL: begin
                    // wdat_ready low here means the last beat's write is on the port this cycle.
                    if (!cfg.wdat_ready) begin
                        state <= S_RSP;
                    end else if (wdat_fire) begin
                        enc        <= 1'b1;
                        wec        <= 1'b1;
                        lutIdc     <= sel_q;
                        addrc      <= addr_q;
                        dinc       <= cfg.wdat;
                        addr_q     <= addr_q + 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == LEN_ONE) cfg.wdat_ready <= 1'b0;
                    end
                end
                S_CLR: begin
                    if (addrc == '1) begin
                        state <= S_RSP;
                    end else begin
                        enc    <= 1'b1;
                        wec    <= 1'b1;
                        lutIdc <= lutIdc;
                        addrc  <= addrc + 1'b1;
                    end
                end
                S_RSP: begin
                    if (cfg.rsp_ready) begin
                        cfg.cmd_ready <= 1'b1;
                        cfg.rsp_data  <= '0;
                        cfg.rsp_err   <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dpd_lut_cfg_ctrl.sv
// Directed bench for dpd_lut_cfg_ctrl with a behavioural LUT row model providing doutc after RD_LATENCY cycles.
module tb_dpd_lut_cfg_ctrl;
    localparam int IDM = 8;
    localparam int DW  = 32;
    localparam int AW  = 3;
    localparam int RDL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enc, wec;
    logic [IDM-1:0] lutIdc;
    logic [AW-1:0] addrc;
    logic [DW-1:0] dinc, doutc;

    dpd_lut_cfg_if #(.I_DELAY_MAX(IDM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dpd_lut_cfg_ctrl #(.I_DELAY_MAX(IDM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg    (bus),
        .enc    (enc),
        .wec    (wec),
        .lutIdc (lutIdc),
        .addrc  (addrc),
        .dinc   (dinc),
        .doutc  (doutc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0]  mem [IDM][2**AW];
    int             rd_run = 0;
    int             wr_cnt = 0;
    int             enc_cnt = 0;
    int             viol = 0;
    int             wr_cyc [512];
    logic [IDM-1:0] last_sel = '0;
    logic [AW-1:0]  last_addr = '0;
    logic [DW-1:0]  last_din = '0;
    bit             init_done = 0;

    // LUT row model and port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < IDM; i++)
                for (int j = 0; j < 2**AW; j++) mem[i][j] = '0;
            init_done = 1;
        end
        if (enc) enc_cnt++;
        if (enc && wec) begin
            for (int i = 0; i < IDM; i++) if (lutIdc[i]) mem[i][addrc] = dinc;
            wr_cyc[wr_cnt % 512] = cyc;
            wr_cnt++;
            last_sel  = lutIdc;
            last_addr = addrc;
            last_din  = dinc;
        end
        if (enc && !wec) rd_run++;
        else rd_run = 0;
        if (enc && !bus.busy) viol++;
        if (bus.cmd_ready && bus.busy) viol++;
        if (bus.wdat_ready && !bus.busy) viol++;
        if (!enc && (wec || lutIdc != '0 || addrc != '0 || dinc != '0)) viol++;
    end

    always_comb begin
        doutc = 32'hDEAD_BEEF;
        if (enc && !wec && rd_run >= RDL)
            for (int i = 0; i < IDM; i++) if (lutIdc[i]) doutc = mem[i][addrc];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] sel, input logic [2:0] addr,
                           input logic [31:0] data, input logic [3:0] len, input logic [31:0] base,
                           input bit stall, input int hold,
                           output logic rerr, output logic [31:0] rdata, output int lat);
        int h, n, k, beats;
        bit got, hs;
        rerr = 0; rdata = 0; lat = -1; h = 0;
        bus.cmd_op = op; bus.cmd_lut_sel = sel; bus.cmd_addr = addr;
        bus.cmd_data = data; bus.cmd_len = len; bus.cmd_valid = 1'b1;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin got = 1; h = cyc; end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        if (!got) begin timeout("cmd_accept"); return; end
        if (op == 2'b10) begin
            beats = (len == 0) ? 8 : int'(len);
            n = 0; k = 0;
            for (int t = 0; t < 100 && n < beats; t++) begin
                bus.wdat_valid = !stall || (k % 2 == 0);
                bus.wdat = base + n;
                k++;
                @(negedge clk);
                hs = bus.wdat_valid && bus.wdat_ready;
                @(posedge clk); #1;
                if (hs) n++;
            end
            bus.wdat_valid = 1'b0;
            if (n < beats) timeout("fill_beats");
        end
        bus.rsp_ready = (hold == 0);
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1; lat = cyc - h; rerr = bus.rsp_err; rdata = bus.rsp_data;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin bus.rsp_ready = 1'b1; timeout("rsp_valid"); return; end
        for (int j = 0; j < hold; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_data", bus.rsp_data, rdata);
            check("hold_rsp_err", bus.rsp_err, rerr);
            check("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rel_rsp_valid", bus.rsp_valid, 0);
        check("rel_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  sel;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  len;
        logic [31:0] base;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_wr;
        int          exp_enc;
        int          exp_lat;
        int          exp_span;
        logic [7:0]  exp_lsel;
        logic [2:0]  exp_laddr;
        logic [31:0] exp_ldin;
    } vec_t;

    vec_t vt [9];

    task automatic check_idle_outputs(input string name);
        check({name, "_port"}, {19'd0, enc, wec, lutIdc, addrc}, 0);
        check({name, "_dinc"}, dinc, 0);
        check({name, "_ctl"}, {27'd0, bus.cmd_ready, bus.wdat_ready, bus.rsp_valid, bus.rsp_err, bus.busy}, 0);
        check({name, "_rsp_data"}, bus.rsp_data, 0);
    endtask

    logic        rerr;
    logic [31:0] rdata;
    int          lat, w0, e0;
    bit          got;

    initial begin
        //            op     sel    addr  data          len   base   err  data          wr enc lat span lsel   laddr ldin
        vt[0] = '{2'b00, 8'h04, 3'd5, 32'h5555_5555, 4'd0, 32'h0,  1'b0, 32'h0,         1, 1, 2,  0,  8'h04, 3'd5, 32'h5555_5555};
        vt[1] = '{2'b01, 8'h04, 3'd5, 32'h0,         4'd0, 32'h0,  1'b0, 32'h5555_5555, 0, 3, 4, -1,  8'h00, 3'd0, 32'h0};
        vt[2] = '{2'b10, 8'h01, 3'd6, 32'h0,         4'd4, 32'hA0, 1'b0, 32'h0,         4, 4, 6,  3,  8'h01, 3'd1, 32'hA3};
        vt[3] = '{2'b01, 8'h01, 3'd0, 32'h0,         4'd0, 32'h0,  1'b0, 32'hA2,        0, 3, 4, -1,  8'h00, 3'd0, 32'h0};
        vt[4] = '{2'b01, 8'h01, 3'd7, 32'h0,         4'd0, 32'h0,  1'b0, 32'hA1,        0, 3, 4, -1,  8'h00, 3'd0, 32'h0};
        vt[5] = '{2'b01, 8'h06, 3'd1, 32'h0,         4'd0, 32'h0,  1'b1, 32'h0,         0, 0, 1, -1,  8'h00, 3'd0, 32'h0};
        vt[6] = '{2'b00, 8'h00, 3'd2, 32'h1234_5678, 4'd0, 32'h0,  1'b1, 32'h0,         0, 0, 1, -1,  8'h00, 3'd0, 32'h0};
        vt[7] = '{2'b11, 8'hFF, 3'd3, 32'h0,         4'd0, 32'h0,  1'b0, 32'h0,         8, 8, 9,  7,  8'hFF, 3'd7, 32'h0};
        vt[8] = '{2'b01, 8'h04, 3'd5, 32'h0,         4'd0, 32'h0,  1'b0, 32'h0,         0, 3, 4, -1,  8'h00, 3'd0, 32'h0};

        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_lut_sel = 0; bus.cmd_addr = 0;
        bus.cmd_data = 0; bus.cmd_len = 0; bus.wdat_valid = 0; bus.wdat = 0; bus.rsp_ready = 1;

        #1 rst_n = 1'b0;
        #2 check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_reset_cmd_ready", bus.cmd_ready, 1);
        check("post_reset_busy", bus.busy, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            w0 = wr_cnt; e0 = enc_cnt;
            run_cmd(vt[i].op, vt[i].sel, vt[i].addr, vt[i].data, vt[i].len, vt[i].base, 0, 0, rerr, rdata, lat);
            check($sformatf("v%0d_err", i), rerr, vt[i].exp_err);
            check($sformatf("v%0d_data", i), rdata, vt[i].exp_data);
            check($sformatf("v%0d_writes", i), wr_cnt - w0, vt[i].exp_wr);
            check($sformatf("v%0d_enc_cycles", i), enc_cnt - e0, vt[i].exp_enc);
            check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
            if (vt[i].exp_span >= 0 && wr_cnt > w0)
                check($sformatf("v%0d_span", i), wr_cyc[(wr_cnt - 1) % 512] - wr_cyc[w0 % 512], vt[i].exp_span);
            if (vt[i].exp_wr > 0) begin
                check($sformatf("v%0d_last_sel", i), last_sel, vt[i].exp_lsel);
                check($sformatf("v%0d_last_addr", i), last_addr, vt[i].exp_laddr);
                check($sformatf("v%0d_last_din", i), last_din, vt[i].exp_ldin);
            end
        end

        // every LUT and address reads back zero after the broadcast clear
        for (int l = 0; l < IDM; l++)
            for (int a = 0; a < 2**AW; a++) begin
                run_cmd(2'b01, 8'(1 << l), 3'(a), 0, 0, 0, 0, 0, rerr, rdata, lat);
                check($sformatf("clr_rd_l%0d_a%0d", l, a), rdata, 0);
            end

        // stalled fill, full depth, wrapping from address 3
        w0 = wr_cnt; e0 = enc_cnt;
        run_cmd(2'b10, 8'h02, 3'd3, 0, 4'd0, 32'hB0, 1, 0, rerr, rdata, lat);
        check("stall_err", rerr, 0);
        check("stall_data", rdata, 0);
        check("stall_writes", wr_cnt - w0, 8);
        check("stall_enc_cycles", enc_cnt - e0, 8);
        check("stall_latency", lat, 17);
        if (wr_cnt > w0) check("stall_span", wr_cyc[(wr_cnt - 1) % 512] - wr_cyc[w0 % 512], 14);
        run_cmd(2'b01, 8'h02, 3'd2, 0, 0, 0, 0, 0, rerr, rdata, lat);
        check("stall_rd_a2", rdata, 32'hB7);
        run_cmd(2'b01, 8'h02, 3'd3, 0, 0, 0, 0, 0, rerr, rdata, lat);
        check("stall_rd_a3", rdata, 32'hB0);

        // response backpressure
        run_cmd(2'b01, 8'h02, 3'd5, 0, 0, 0, 0, 10, rerr, rdata, lat);
        check("bp_data", rdata, 32'hB2);
        check("bp_latency", lat, 4);

        // reset in the middle of a fill
        bus.cmd_op = 2'b10; bus.cmd_lut_sel = 8'h08; bus.cmd_addr = 3'd0; bus.cmd_len = 4'd8;
        bus.cmd_valid = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = bus.cmd_ready;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wdat_valid = 1'b1;
            bus.wdat = 32'hC0 + i;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("mid_fill_reset");
        bus.wdat_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_rsp_valid", bus.rsp_valid, 0);
        end
        check("post_abort_busy", bus.busy, 0);
        check("post_abort_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;
        run_cmd(2'b01, 8'h08, 3'd1, 0, 0, 0, 0, 0, rerr, rdata, lat);
        check("post_abort_rd_a1", rdata, 32'hC1);
        run_cmd(2'b01, 8'h08, 3'd0, 0, 0, 0, 0, 0, rerr, rdata, lat);
        check("post_abort_rd_a0", rdata, 32'hC0);

        check("port_monitor_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dpd_lut_cfg_ctrl.md
Name: dpd_lut_cfg_ctrl

Overview:
- Configuration sequencer for the DPD LUT row configuration port (enc/lutIdc/wec/addrc/dinc/doutc).
- Accepts host commands through a valid/ready command channel: single write, single read, burst fill from a data stream, and clear.
- Generates cycle-exact LUT port timing, including the multi-cycle read latency, and returns a response per command.
- Sits between the AXI register bank and one dpd_luts_row_v2 instance.

Parameters:
I_DELAY_MAX, 8, number of LUTs in the row (width of lutIdc)
DATA_WIDTH, 32, LUT entry width
ADDR_WIDTH, 3, LUT address width (depth 2**ADDR_WIDTH)
RD_LATENCY, 3, cycles enc must be held before doutc is valid

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_op  in  2  00 write, 01 read, 10 fill, 11 clear
cmd_lut_sel  in  I_DELAY_MAX  LUT select mask
cmd_addr  in  ADDR_WIDTH  start address
cmd_data  in  DATA_WIDTH  write data (op 00 only)
cmd_len  in  ADDR_WIDTH+1  fill length; 0 means 2**ADDR_WIDTH
wdat_valid  in  1  fill data valid
wdat_ready  out  1  fill data ready
wdat  in  DATA_WIDTH  fill data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_data  out  DATA_WIDTH  read data (0 for non-read ops)
rsp_err  out  1  command rejected
busy  out  1  high in every state except IDLE
enc, wec  out  1  LUT port enable and write enable
lutIdc  out  I_DELAY_MAX  LUT select
addrc  out  ADDR_WIDTH  LUT address
dinc  out  DATA_WIDTH  LUT write data
doutc  in  DATA_WIDTH  LUT read data

Behaviour:
- Reset values:
  - All outputs 0, state IDLE.
  - Asserting reset mid-command drops the command and any pending response; there is no partial-response recovery.
- All LUT-side outputs are registered. When no access is in progress, enc, wec, lutIdc, addrc and dinc are 0.
- States: IDLE, WR, RD, FILL, CLR, RSP.
- IDLE:
  - cmd_ready=1; this is the only state where it is high.
  - On handshake, latch all cmd_* fields.
  - If cmd_lut_sel==0, or if op is read and cmd_lut_sel is not one-hot, go to RSP with rsp_err=1. No LUT access occurs.
  - Otherwise go to the state for the op. Multi-bit masks broadcast writes, fills and clears.
- WR: exactly one cycle with enc=1, wec=1 and the latched lutIdc/addrc/dinc; then RSP.
- RD:
  - enc=1, wec=0 and lutIdc/addrc held for RD_LATENCY consecutive cycles.
  - At the clock edge ending the last enc cycle, doutc is captured into rsp_data; then RSP.
  - Command acceptance to rsp_valid takes RD_LATENCY+1 cycles.
- FILL:
  - wdat_ready=1.
  - Each wdat handshake produces one write cycle on the following clock edge, at the current address with dinc=wdat.
  - Address increments modulo 2**ADDR_WIDTH and wraps (7 to 0 for the default ADDR_WIDTH).
  - Back-to-back beats produce back-to-back write cycles. Gaps in wdat_valid produce enc=0 cycles.
  - After cmd_len beats, wdat_ready drops in the same cycle as the last handshake; then RSP.
- CLR: 2**ADDR_WIDTH consecutive write cycles of dinc=0 at addresses 0 to max, ignoring cmd_addr; then RSP.
- RSP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready.
  - On the rsp_valid && rsp_ready cycle, go to IDLE. rsp_valid drops next cycle, and cmd_ready rises next cycle.
  - rsp_data=0 for write, fill and clear.
- The LUT port is never driven outside WR/RD/FILL/CLR, and only one command is in flight at a time.
- wdat presented outside FILL is not accepted (wdat_ready=0).

Test Plan:
- Write then read: write lut_sel=0x04, addr=5, data=0x5555_5555, then read the same location -> exactly one enc&wec cycle with lutIdc=0x04, addrc=5; read holds enc for 3 cycles; rsp_data=0x5555_5555, rsp_err=0, rsp_valid 4 cycles after acceptance.
- Fill with wrap: fill lut_sel=0x01, addr=6, len=4, wdat=0xA0..0xA3 back-to-back -> writes at addresses 6,7,0,1 on consecutive cycles; readback of address 0 returns 0xA2.
- Stalled fill: wdat_valid toggles 1/0 for len=0 (8 beats) -> 8 write cycles interleaved with enc=0 cycles; one response after the 8th beat.
- Broadcast clear: lut_sel=0xFF, op=11 after a prior fill -> 8 write cycles with dinc=0 and lutIdc=0xFF; reads of every LUT at addresses 0..7 return 0.
- Errors: read with lut_sel=0x06, and write with lut_sel=0x00 -> rsp_err=1, enc never asserted.
- Backpressure and reset: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0. Separately, assert rst_n=0 mid-fill -> all outputs 0 immediately, state IDLE, no response.
